can_frame_tx: RTL and testbench
===============================

// Module: can_frame_tx
// PURPOSE
//  Parametrised CAN-style serial frame transmitter; successor to the fixed 11-bit/1-byte sender.
//  Accepts ID, DLC and payload via valid/ready handshake and serialises on tx (1 = recessive).
//  Serialised fields: SOF, ID, RTR, DLC, data, CRC-15, delimiters, EOF, IFS.
//  Programmable bit time. Sits between the message scheduler and the bus transceiver pad.
// PARAMETERS
//  ID_W      11  identifier width; legal values are 11 or 29
//  MAX_BYTES 8   payload capacity in bytes (1..8)
//  BIT_DIV   4   clk cycles per bus bit (>=1)
// PORTS
//  clk       in  1              clock
//  rst_n     in  1              asynchronous reset, active-low
//  in_valid  in  1              frame request
//  in_ready  out 1              high only in IDLE
//  in_id     in  ID_W           identifier, sent MSB first
//  in_dlc    in  4              data length code
//  in_data   in  8*MAX_BYTES    byte k = in_data[8k+7:8k]; byte0 sent first, MSB first
//  tx        out 1              serial bus output
//  busy      out 1              high whenever state != IDLE
//  done      out 1              1-cycle pulse at frame end
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx=1, busy=0, done=0, bit timer=0, stuff counters=0.
//    in_ready=1 after reset.
//    Reset mid-frame aborts the frame; tx returns to 1 immediately; no done pulse.
//  Accept: in_valid&&in_ready at edge N latches id/dlc/data.
//    From edge N+1: busy=1, in_ready=0, tx=0 (SOF).
//    in_* are don't-care after acceptance.
//  Bit timing: each bus bit is held exactly BIT_DIV clks. tx changes only at bit boundaries.
//  States and fields (bits, unstuffed):
//    IDLE -> SOF(1,'0') -> ID(ID_W) -> CTRL(RTR '0' + DLC 4 bits, MSB first)
//    -> DATA(8*nb) -> CRC(15, MSB first) -> TAIL(CRC delim '1', ACK slot '1', ACK delim '1', EOF 7x'1')
//    -> IFS(3x'1') -> IDLE.
//  Data byte count: nb = min(in_dlc, MAX_BYTES). The DLC field is sent as given.
//    If nb==0, DATA is skipped (CTRL -> CRC).
//  CRC-15: poly 0x4599, init 0. Computed over SOF..last data bit (stuff bits excluded).
//    Updated at each field-bit boundary: crc = {crc[13:0],1'b0} ^ ((bit^crc[14]) ? 15'h4599 : 0).
//  done: asserted for exactly 1 clk, on the clk the FSM re-enters IDLE.
//    in_ready=1 in that same clk, so back-to-back frames lose no extra cycles.
//  Simultaneous in_valid with done/IDLE entry: the frame is accepted normally.
//    in_valid while busy is ignored (no queuing).
//  Unstuffed length L = 1+ID_W+1+4+8*nb+15+3+7+3. busy lasts L*BIT_DIV clks (plus stuff bits if enabled).
// CONFIGURATION
//  CAN_TX_BIT_STUFF_EN defined:
//    - Region SOF..last CRC bit: after 5 consecutive equal tx bits, insert 1 complement bit (BIT_DIV clks).
//    - The stuff bit starts the new run (count=1).
//    - Stuff bits are excluded from the CRC.
//    - The field/bit counter does not advance during a stuff bit.
//    - Stuffing off from CRC delimiter onward. A stuff due after the last CRC bit is still inserted.
//  Undefined: no stuffing. tx is the raw field sequence; frame length is exactly L bits.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> tx=1, busy=0, done=0, in_ready=1 after release; no frame started.
//  2 ID_W=11, BIT_DIV=4, no stuff, id=0x555, dlc=1, byte0=0xA5:
//    -> SOF=0, then 101_0101_0101, 0, 0001, 1010_0101, CRC per model.
//    -> 1111111111, 111; busy=53*4=212 clks; done at clk 213 after accept.
//  3 With CAN_TX_BIT_STUFF_EN, id=0, dlc=0:
//    -> first 32 zeros (SOF..CRC) carry stuff '1' after zeros 5,10,15,20,25,30.
//    -> frame = 51 bits = 204 clks.
//  4 dlc=15 with MAX_BYTES=8 -> DLC field 1111, exactly 64 data bits sent, CRC over 8 bytes.
//  5 Back-to-back: in_valid held high -> second SOF starts the clk after done; zero idle bits beyond IFS.
//  6 Reset mid-DATA (rst_n low 1 clk) -> tx=1 same cycle, done never pulses, next accepted frame is correct.
//  Also: ID_W=29, BIT_DIV=1 frame compared bit-by-bit with reference model.

Source files
------------

// File: rtl/can_frame_tx_if.sv
// Frame request / serial output bundle between the message scheduler (master) and can_frame_tx (slave).
// in_* qualified by in_valid && in_ready; tx/busy/done are status from the transmitter.
interface can_frame_tx_if #(
    parameter int ID_W      = 11,
    parameter int MAX_BYTES = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ID_W-1:0]        in_id;
    logic [3:0]             in_dlc;
    logic [8*MAX_BYTES-1:0] in_data;
    logic                   tx;
    logic                   busy;
    logic                   done;

    modport master (
        output in_valid, in_id, in_dlc, in_data,
        input  in_ready, tx, busy, done
    );

    modport slave (
        input  in_valid, in_id, in_dlc, in_data,
        output in_ready, tx, busy, done
    );
endinterface

// File: rtl/can_frame_tx.sv
// CAN-style serialiser (SOF..IFS, CRC-15, BIT_DIV clks/bit); SOF on tx the cycle after accept, done on IDLE re-entry.
// Backpressure: in_ready only in IDLE, no queuing. Bit stuffing SOF..CRC enabled by `define CAN_TX_BIT_STUFF_EN.
module can_frame_tx #(
    parameter int ID_W      = 11,
    parameter int MAX_BYTES = 8,
    parameter int BIT_DIV   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    can_frame_tx_if.slave bus
);
    localparam int DW = 8 * MAX_BYTES;
    localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
`ifdef CAN_TX_BIT_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_ID, S_CTRL, S_DATA, S_CRC, S_TAIL, S_IFS
    } state_t;

    // Latched request; data is byte-reordered so the first bit on the wire is the MSB.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      dlc;
        logic [DW-1:0]   data;
        logic [6:0]      nbits;
    } frame_t;

    state_t        state, nstate;
    frame_t        frm;
    logic [6:0]    pos, npos;
    logic [TW-1:0] timer;
    logic [14:0]   crc, crc_step, crc_upd;
    logic [2:0]    run;
    logic          stuffing;
    logic          tx_r, done_r;
    logic          bit_end, in_region, crc_region, stuff_due, nbit;
    logic [DW-1:0] ser_in;
    logic [6:0]    nbits_in;

    logic [ID_W-1:0] id_sh;
    logic [DW-1:0]   dat_sh;
    logic [4:0]      ctl_sh;
    logic [14:0]     crc_sh;

    assign bus.in_ready = (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.tx       = tx_r;
    assign bus.done     = done_r;

    always_comb begin
        ser_in = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            ser_in[DW-1-8*k -: 8] = bus.in_data[8*k +: 8];
    end

    assign nbits_in = (bus.in_dlc > 4'(MAX_BYTES)) ? 7'(8 * MAX_BYTES) : {bus.in_dlc, 3'b000};

    assign bit_end    = (timer == TW'(BIT_DIV - 1));
    assign crc_region = (state == S_SOF) || (state == S_ID) || (state == S_CTRL) || (state == S_DATA);
    assign in_region  = crc_region || (state == S_CRC);
    assign stuff_due  = STUFF_EN && in_region && (run == 3'd5);

    assign crc_step = {crc[13:0], 1'b0} ^ ((tx_r ^ crc[14]) ? 15'h4599 : 15'h0000);
    assign crc_upd  = (!stuffing && crc_region) ? crc_step : crc;

    // Field position that follows the field bit currently on the wire.
    always_comb begin
        nstate = state;
        npos   = pos + 7'd1;
        unique case (state)
            S_SOF:  begin nstate = S_ID; npos = 7'd0; end
            S_ID:   if (pos == 7'(ID_W - 1)) begin
                        nstate = S_CTRL; npos = 7'd0;
                    end
            S_CTRL: if (pos == 7'd4) begin
                        nstate = (frm.nbits == 7'd0) ? S_CRC : S_DATA; npos = 7'd0;
                    end
            S_DATA: if (pos == frm.nbits - 7'd1) begin
                        nstate = S_CRC; npos = 7'd0;
                    end
            S_CRC:  if (pos == 7'd14) begin
                        nstate = S_TAIL; npos = 7'd0;
                    end
            S_TAIL: if (pos == 7'd9) begin
                        nstate = S_IFS; npos = 7'd0;
                    end
            S_IFS:  if (pos == 7'd2) begin
                        nstate = S_IDLE; npos = 7'd0;
                    end
            default: npos = 7'd0;
        endcase
    end

    always_comb begin
        nbit   = 1'b1;
        id_sh  = frm.id << npos;
        dat_sh = frm.data << npos;
        ctl_sh = {1'b0, frm.dlc} << npos;
        crc_sh = crc_upd << npos;
        unique case (nstate)
            S_ID:    nbit = id_sh[ID_W-1];
            S_CTRL:  nbit = ctl_sh[4];
            S_DATA:  nbit = dat_sh[DW-1];
            S_CRC:   nbit = crc_sh[14];
            default: nbit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            frm      <= '0;
            pos      <= 7'd0;
            timer    <= '0;
            crc      <= 15'd0;
            run      <= 3'd0;
            stuffing <= 1'b0;
            tx_r     <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == S_IDLE) begin
                timer <= '0;
                if (bus.in_valid) begin
                    frm      <= '{id: bus.in_id, dlc: bus.in_dlc, data: ser_in, nbits: nbits_in};
                    state    <= S_SOF;
                    pos      <= 7'd0;
                    crc      <= 15'd0;
                    run      <= 3'd1;
                    stuffing <= 1'b0;
                    tx_r     <= 1'b0;
                end
            end else if (!bit_end) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
                crc   <= crc_upd;
                if (stuff_due) begin
                    // Position holds still; the complement bit opens a new run.
                    tx_r     <= ~tx_r;
                    run      <= 3'd1;
                    stuffing <= 1'b1;
                end else begin
                    stuffing <= 1'b0;
                    state    <= nstate;
                    pos      <= npos;
                    tx_r     <= nbit;
                    run      <= (nbit == tx_r) ? run + 3'd1 : 3'd1;
                    if (nstate == S_IDLE)
                        done_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench: two transmitters (ID 11 / 4 clk per bit, ID 29 / 1 clk per bit) against a bit-list reference.
// Honours CAN_TX_BIT_STUFF_EN the same way as the design build.
module tb_can_frame_tx;
`ifdef CAN_TX_BIT_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    can_frame_tx_if #(.ID_W(11), .MAX_BYTES(8)) if0();
    can_frame_tx_if #(.ID_W(29), .MAX_BYTES(8)) if1();

    can_frame_tx #(.ID_W(11), .MAX_BYTES(8), .BIT_DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    can_frame_tx #(.ID_W(29), .MAX_BYTES(8), .BIT_DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int          sel = 0;
    logic        v_valid = 1'b0;
    logic [28:0] v_id = '0;
    logic [3:0]  v_dlc = '0;
    logic [63:0] v_data = '0;

    assign if0.in_valid = v_valid && (sel == 0);
    assign if0.in_id    = v_id[10:0];
    assign if0.in_dlc   = v_dlc;
    assign if0.in_data  = v_data;
    assign if1.in_valid = v_valid && (sel == 1);
    assign if1.in_id    = v_id;
    assign if1.in_dlc   = v_dlc;
    assign if1.in_data  = v_data;

    wire s_tx    = (sel == 1) ? if1.tx       : if0.tx;
    wire s_busy  = (sel == 1) ? if1.busy     : if0.busy;
    wire s_ready = (sel == 1) ? if1.in_ready : if0.in_ready;
    wire s_done  = (sel == 1) ? if1.done     : if0.done;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    typedef struct {
        int          s;
        logic [28:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          len;    // frame bits; 0 = take length from the reference list
        logic [63:0] pre;    // hand-derived leading bits, first bit at pre[pre_n-1]
        int          pre_n;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic build(input int s, input logic [28:0] id, input logic [3:0] dlc, input logic [63:0] data);
        bit raw[$];
        logic [14:0] crc;
        logic [28:0] idv;
        logic [63:0] dv;
        logic [3:0]  dl;
        int nb, idw, run;
        bit prev;
        idw = (s == 1) ? 29 : 11;
        raw.push_back(1'b0);
        for (int i = idw - 1; i >= 0; i--) begin idv = id >> i; raw.push_back(idv[0]); end
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) begin dl = dlc >> i; raw.push_back(dl[0]); end
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        for (int k = 0; k < nb; k++)
            for (int i = 7; i >= 0; i--) begin dv = data >> (8 * k + i); raw.push_back(dv[0]); end
        crc = 15'd0;
        foreach (raw[j]) crc = {crc[13:0], 1'b0} ^ ((raw[j] ^ crc[14]) ? 15'h4599 : 15'h0000);
        for (int i = 14; i >= 0; i--) raw.push_back(crc[14 - (14 - i)] == crc[14 - (14 - i)] ? bit'(crc >> i) : 1'b0);
        exp_q.delete();
        prev = 1'b1;
        run  = 0;
        foreach (raw[j]) begin
            exp_q.push_back(raw[j]);
            if (STUFF) begin
                run  = (raw[j] == prev) ? run + 1 : 1;
                prev = raw[j];
                if (run == 5) begin
                    exp_q.push_back(!prev);
                    prev = !prev;
                    run  = 1;
                end
            end
        end
        repeat (13) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input int s, input logic [28:0] id, input logic [3:0] dlc, input logic [63:0] data,
                             input int len, input logic [63:0] pre, input int pre_n, input bit hold, input string nm);
        int div, c, nbits, bad_bits, bad_rdy, bad_done, pbad;
        bit cap[$];
        logic [63:0] p;
        sel = s;
        div = (s == 1) ? 1 : 4;
        build(s, id, dlc, data);
        nbits = (len > 0) ? len : exp_q.size();
        c = 0;
        while (!s_ready && c < 1000) begin @(posedge clk); #1; c++; end
        chk({nm, " ready"}, s_ready, 1);
        @(negedge clk);
        v_id = id; v_dlc = dlc; v_data = data; v_valid = 1'b1;
        @(posedge clk); #1;
        chk({nm, " accept"}, {s_busy, s_tx}, 2'b10);
        if (!hold) v_valid = 1'b0;
        v_id = ~id; v_dlc = ~dlc; v_data = ~data;
        c = 0; bad_bits = 0; bad_rdy = 0; bad_done = 0;
        while (s_busy && c < nbits * div + 50) begin
            if (c / div < exp_q.size()) begin
                if (s_tx !== exp_q[c / div]) bad_bits++;
            end else bad_bits++;
            if (c % div == div / 2) cap.push_back(s_tx);
            if (s_ready !== 1'b0) bad_rdy++;
            if (s_done !== 1'b0) bad_done++;
            @(posedge clk); #1;
            c++;
        end
        chk({nm, " bits"}, bad_bits, 0);
        chk({nm, " ready low while busy"}, bad_rdy, 0);
        chk({nm, " done low while busy"}, bad_done, 0);
        chk({nm, " busy clks"}, c, nbits * div);
        chk({nm, " done/ready at end"}, {s_done, s_ready, s_tx}, 3'b111);
        if (pre_n > 0) begin
            pbad = 0;
            for (int i = 0; i < pre_n; i++) begin
                p = pre >> (pre_n - 1 - i);
                if (i >= cap.size() || cap[i] !== p[0]) pbad++;
            end
            chk({nm, " hand prefix"}, pbad, 0);
        end
        if (!hold) begin
            @(posedge clk); #1;
            chk({nm, " done one clk"}, s_done, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcnt;
        vt[0] = '{0, 29'h555, 4'd1, 64'hA5, STUFF ? 0 : 53,
                  64'(25'b0_10101010101_0_0001_10100101), 25};
        vt[1] = '{0, 29'h0, 4'd0, 64'h0, STUFF ? 51 : 45,
                  STUFF ? {13'd0, 36'h041041041, 2'b00, 13'h1FFF} : 64'h1FFF, STUFF ? 51 : 45};
        vt[2] = '{0, 29'h123, 4'd15, 64'h0123456789ABCDEF, STUFF ? 0 : 109,
                  STUFF ? 64'(13'b0_00100100011_0) : 64'(25'b0_00100100011_0_1111_11101111), STUFF ? 13 : 25};
        vt[3] = '{0, 29'h7FF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, STUFF ? 0 : 109,
                  STUFF ? 64'(19'b0111110111110101000) : 64'(17'b0_11111111111_0_1000), STUFF ? 19 : 17};
        vt[4] = '{0, 29'h0F0, 4'd2, 64'h5A3C, STUFF ? 0 : 61, 64'h0, 0};
        vt[5] = '{1, 29'h12345678, 4'd3, 64'h112233, STUFF ? 0 : 87, 64'({1'b0, 29'h12345678}), 30};
        vt[6] = '{1, 29'h0, 4'd0, 64'h0, STUFF ? 73 : 63,
                  STUFF ? 64'h0410_4104_1041_041F : 64'h1FFF, STUFF ? 64 : 63};

        // Reset held with a pending request: nothing may start.
        v_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs u0", {if0.tx, if0.busy, if0.done}, 3'b100);
        chk("reset outputs u1", {if1.tx, if1.busy, if1.done}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        v_valid = 1'b0;
        #1;
        chk("ready after reset", {if0.in_ready, if1.in_ready}, 2'b11);
        @(posedge clk); #1;
        chk("no frame from reset", {if0.busy, if1.busy, if0.tx, if1.tx}, 4'b0011);

        for (int i = 0; i < 7; i++)
            run_frame(vt[i].s, vt[i].id, vt[i].dlc, vt[i].data, vt[i].len, vt[i].pre, vt[i].pre_n,
                      1'b0, $sformatf("vec%0d", i));

        // Back-to-back: request held through the frame and the done cycle.
        run_frame(vt[0].s, vt[0].id, vt[0].dlc, vt[0].data, vt[0].len, vt[0].pre, vt[0].pre_n, 1'b1, "b2b first");
        run_frame(vt[4].s, vt[4].id, vt[4].dlc, vt[4].data, vt[4].len, vt[4].pre, vt[4].pre_n, 1'b0, "b2b second");

        // Reset in the middle of the data field.
        sel = 0;
        @(negedge clk);
        v_id = 29'h2A; v_dlc = 4'd8; v_data = 64'h0; v_valid = 1'b1;
        @(posedge clk); #1;
        v_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("busy before mid reset", if0.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset outputs", {if0.tx, if0.busy, if0.done, if0.in_ready}, 4'b1001);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) dcnt++;
        end
        chk("no done after mid reset", dcnt, 0);
        run_frame(vt[2].s, vt[2].id, vt[2].dlc, vt[2].data, vt[2].len, vt[2].pre, vt[2].pre_n, 1'b0, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
